// File: rtl/xoodoo_pkg.sv
// Shared definitions for the masked Xoodoo permutation sequencer.
//   state_e     : sequencer FSM encoding
//   J_LAST_BIT  : index of the round-token bit that marks the final capture
//   XOODOO_W    : state width per share
//   j_start()   : one-hot token issued with the first round of an n-round permutation
package xoodoo_pkg;

  localparam int unsigned J_LAST_BIT = 12;
  localparam int unsigned XOODOO_W   = 384;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // A run of n rounds uses the last n tokens, so it starts at bit (12 - n).
  function automatic logic [J_LAST_BIT:0] j_start(input int unsigned nrounds);
    return (J_LAST_BIT + 1)'(1) << (J_LAST_BIT - nrounds);
  endfunction

endpackage

// File: rtl/xoodoo_round_timer.sv
// Round latency down-counter.
//   clk, rst  : clock, asynchronous active-low reset
//   load_i    : load RoundLat-1 (round issued to the core)
//   en_i      : count down while non-zero (core busy)
//   expired_o : counter at zero, core output is valid
module xoodoo_round_timer #(
  parameter int unsigned RoundLat = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (RoundLat > 1) ? $clog2(RoundLat) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(RoundLat - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/xoodoo_perm_ctrl_sca.sv
// Sequencer running one full two-share masked Xoodoo permutation on an external
// round core. Owns both share registers, the per-round randomness register and
// the one-hot round token.
//   start_i / in0_i / in1_i      : start a permutation with the given shares (IDLE only)
//   rnd_i / rnd_valid_i          : fresh randomness, one word consumed per round
//   rnd_req_o                    : rnd_i consumed this cycle
//   busy_o / done_o              : run in progress / one-cycle completion pulse
//   out0_o / out1_o              : result shares (the share registers)
//   core_*_o / core_*_i          : round core interface
// Optional build macro XOODOO_PERM_CNT_EN adds perm_cnt_o (completed runs, wrapping)
// and stall_cnt_o (ISSUE cycles starved of randomness, saturating).
module xoodoo_perm_ctrl_sca
  import xoodoo_pkg::*;
#(
  parameter int unsigned W         = XOODOO_W,
  parameter int unsigned NROUNDS   = 12,
  parameter int unsigned ROUND_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [W-1:0]          in0_i,
  input  logic [W-1:0]          in1_i,
  input  logic [W-1:0]          rnd_i,
  input  logic                  rnd_valid_i,
  output logic                  rnd_req_o,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef XOODOO_PERM_CNT_EN
  output logic [31:0]           perm_cnt_o,
  output logic [15:0]           stall_cnt_o,
`endif
  output logic [W-1:0]          out0_o,
  output logic [W-1:0]          out1_o,
  output logic [W-1:0]          core_in0_o,
  output logic [W-1:0]          core_in1_o,
  output logic [W-1:0]          core_rdi_o,
  output logic                  core_rdi_en_o,
  output logic [J_LAST_BIT:0]   core_j_o,
  input  logic [W-1:0]          core_out0_i,
  input  logic [W-1:0]          core_out1_i,
  input  logic [J_LAST_BIT:0]   core_j_i
);

  state_e              state_q, state_d;
  logic [W-1:0]        share0_q, share0_d;
  logic [W-1:0]        share1_q, share1_d;
  logic [W-1:0]        rdi_q, rdi_d;
  logic [J_LAST_BIT:0] j_q, j_d;
  logic                timer_load, timer_en, timer_expired;

  xoodoo_round_timer #(
    .RoundLat (ROUND_LAT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    share0_d      = share0_q;
    share1_d      = share1_q;
    rdi_d         = rdi_q;
    j_d           = j_q;
    rnd_req_o     = 1'b0;
    core_rdi_en_o = 1'b0;
    done_o        = 1'b0;
    busy_o        = 1'b1;
    timer_load    = 1'b0;
    timer_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        if (start_i) begin
          share0_d = in0_i;
          share1_d = in1_i;
          j_d      = j_start(NROUNDS);
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (rnd_valid_i) begin
          rdi_d      = rnd_i;
          rnd_req_o  = 1'b1;
          timer_load = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        core_rdi_en_o = 1'b1;
        timer_en      = 1'b1;
        if (timer_expired) begin
          share0_d = core_out0_i;
          share1_d = core_out1_i;
          j_d      = core_j_i;
          state_d  = core_j_i[J_LAST_BIT] ? StDone : StIssue;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        // Drop the last mask so it does not linger after the run.
        rdi_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      share0_q <= '0;
      share1_q <= '0;
      rdi_q    <= '0;
      j_q      <= '0;
    end else begin
      state_q  <= state_d;
      share0_q <= share0_d;
      share1_q <= share1_d;
      rdi_q    <= rdi_d;
      j_q      <= j_d;
    end
  end

  assign out0_o     = share0_q;
  assign out1_o     = share1_q;
  assign core_in0_o = share0_q;
  assign core_in1_o = share1_q;
  assign core_rdi_o = rdi_q;
  assign core_j_o   = j_q;

`ifdef XOODOO_PERM_CNT_EN
  logic [31:0] perm_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perm_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == StDone) begin
        perm_cnt_q <= perm_cnt_q + 32'd1;
      end
      if ((state_q == StIssue) && !rnd_valid_i && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign perm_cnt_o  = perm_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_xoodoo_perm_ctrl_sca.sv
// Directed self-checking bench for xoodoo_perm_ctrl_sca. A combinational round
// core stub (out0 = in0 ^ rdi ^ j, out1 = in1 ^ rdi, j_out = j << 1) is attached
// to a 12-round DUT and to a 6-round DUT that share the upstream stimulus.
module tb_xoodoo_perm_ctrl_sca;

  localparam int unsigned W  = 384;
  localparam int unsigned NR = 12;

  logic          clk, rst, start, rnd_valid;
  logic [W-1:0]  in0, in1, rnd;

  logic          rnd_req, busy, done, crdi_en;
  logic [W-1:0]  out0, out1, cin0, cin1, crdi, cout0, cout1;
  logic [12:0]   cj, cjn;

  logic          rnd_req6, busy6, done6, crdi_en6;
  logic [W-1:0]  out06, out16, cin06, cin16, crdi6, cout06, cout16;
  logic [12:0]   cj6, cjn6;

`ifdef XOODOO_PERM_CNT_EN
  logic [31:0] perm_cnt, perm_cnt6;
  logic [15:0] stall_cnt, stall_cnt6;
  int exp_perm = 0;
  int exp_stall = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  assign cout0 = cin0 ^ (crdi & {W{crdi_en}}) ^ W'(cj);
  assign cout1 = cin1 ^ (crdi & {W{crdi_en}});
  assign cjn   = cj << 1;
  assign cout06 = cin06 ^ (crdi6 & {W{crdi_en6}}) ^ W'(cj6);
  assign cout16 = cin16 ^ (crdi6 & {W{crdi_en6}});
  assign cjn6   = cj6 << 1;

  xoodoo_perm_ctrl_sca #(.W(W), .NROUNDS(12), .ROUND_LAT(2)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .in0_i         (in0),
    .in1_i         (in1),
    .rnd_i         (rnd),
    .rnd_valid_i   (rnd_valid),
    .rnd_req_o     (rnd_req),
    .busy_o        (busy),
    .done_o        (done),
`ifdef XOODOO_PERM_CNT_EN
    .perm_cnt_o    (perm_cnt),
    .stall_cnt_o   (stall_cnt),
`endif
    .out0_o        (out0),
    .out1_o        (out1),
    .core_in0_o    (cin0),
    .core_in1_o    (cin1),
    .core_rdi_o    (crdi),
    .core_rdi_en_o (crdi_en),
    .core_j_o      (cj),
    .core_out0_i   (cout0),
    .core_out1_i   (cout1),
    .core_j_i      (cjn)
  );

  xoodoo_perm_ctrl_sca #(.W(W), .NROUNDS(6), .ROUND_LAT(2)) u_dut6 (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .in0_i         (in0),
    .in1_i         (in1),
    .rnd_i         (rnd),
    .rnd_valid_i   (rnd_valid),
    .rnd_req_o     (rnd_req6),
    .busy_o        (busy6),
    .done_o        (done6),
`ifdef XOODOO_PERM_CNT_EN
    .perm_cnt_o    (perm_cnt6),
    .stall_cnt_o   (stall_cnt6),
`endif
    .out0_o        (out06),
    .out1_o        (out16),
    .core_in0_o    (cin06),
    .core_in1_o    (cin16),
    .core_rdi_o    (crdi6),
    .core_rdi_en_o (crdi_en6),
    .core_j_o      (cj6),
    .core_out0_i   (cout06),
    .core_out1_i   (cout16),
    .core_j_i      (cjn6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_of(input int c);
    logic [31:0] w;
    w = 32'h9E37_79B9 * 32'(c + 1) ^ 32'h5A5A_0000;
    return {12{w}};
  endfunction

`ifdef XOODOO_PERM_CNT_EN
  task automatic check_cnts();
    check_eq("perm_cnt", W'(perm_cnt), W'(exp_perm));
    check_eq("stall_cnt", W'(stall_cnt), W'(exp_stall));
  endtask
`endif

  // One 12-round run starting with start sampled at edge 0 (cycle 0). Inputs for
  // cycle i are driven at its negedge and outputs sampled 1 time unit later.
  // rnd_valid is low for cycles [st_at, st_at+st_len). extra_start pulses start
  // in a WAIT cycle and in the DONE cycle.
  task automatic run_perm(input logic [W-1:0] a0, input logic [W-1:0] a1,
                          input int st_at, input int st_len, input bit extra_start);
    logic [W-1:0] g0, g1, r;
    logic [W-1:0] pre0 [NR];
    logic [W-1:0] pre1 [NR];
    int           iss [NR];
    logic [12:0]  tok;
    int           t, exp_done, k, nreq, ndone;
    bit           stall;

    // Reference schedule and golden shares.
    g0 = a0; g1 = a1; tok = 13'h001; t = 1;
    for (int n = 0; n < NR; n++) begin
      while (t >= st_at && t < st_at + st_len) t++;
      iss[n]  = t;
      pre0[n] = g0;
      pre1[n] = g1;
      r  = rnd_of(t);
      g0 = g0 ^ r ^ W'(tok);
      g1 = g1 ^ r;
      tok = tok << 1;
      t  = t + 3;
    end
    exp_done = t;

    k = 0; nreq = 0; ndone = 0;
    for (int i = 0; i < exp_done + 4; i++) begin
      @(negedge clk);
      stall     = (i >= st_at) && (i < st_at + st_len);
      start     = (i == 0) || (extra_start && (i == 2 || i == exp_done));
      in0       = a0;
      in1       = a1;
      rnd_valid = !stall;
      rnd       = rnd_of(i);
      #1;
      if (i > 0) begin
        check_eq("busy", W'(busy), W'(i <= exp_done));
        check_eq("done", W'(done), W'(i == exp_done));
        if (done) ndone++;
        if (rnd_req) nreq++;
        check_eq("rnd_req", W'(rnd_req), W'(k < NR && i == iss[k]));
        if (k < NR && (stall || i == iss[k])) begin
          check_eq("token", W'(cj), W'(13'h001 << k));
          check_eq("share0_held", out0, pre0[k]);
          check_eq("share1_held", out1, pre1[k]);
        end
        if (k < NR && i == iss[k]) k++;
        if (i > exp_done) check_eq("rdi_cleared", crdi, '0);
      end
    end
    start = 1'b0;
    check_eq("out0", out0, g0);
    check_eq("out1", out1, g1);
    check_eq("n_rnd_req", W'(nreq), W'(NR));
    check_eq("n_done", W'(ndone), W'(1));
    check_eq("final_token", W'(cj), W'(13'h1000));
`ifdef XOODOO_PERM_CNT_EN
    exp_perm++;
    exp_stall += st_len;
    check_cnts();
`endif
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rnd_valid = 1'b0;
    in0 = '0; in1 = '0; rnd = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start     = 1'($urandom);
      rnd_valid = 1'($urandom);
      in0       = {12{$urandom}};
      in1       = {12{$urandom}};
      rnd       = {12{$urandom}};
    end
    #1;
    check_eq("rst_out0", out0, '0);
    check_eq("rst_out1", out1, '0);
    check_eq("rst_core_in0", cin0, '0);
    check_eq("rst_core_in1", cin1, '0);
    check_eq("rst_core_rdi", crdi, '0);
    check_eq("rst_rdi_en", W'(crdi_en), '0);
    check_eq("rst_core_j", W'(cj), '0);
    check_eq("rst_rnd_req", W'(rnd_req), '0);
    check_eq("rst_busy", W'(busy), '0);
    check_eq("rst_done", W'(done), '0);
    @(negedge clk);
    start = 1'b0; rnd_valid = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("post_rst_busy", W'(busy), '0);
    check_eq("post_rst_j", W'(cj), '0);
`ifdef XOODOO_PERM_CNT_EN
    check_cnts();
`endif

    // Nominal, stall during round 3, ignored starts.
    run_perm('0, '0, 0, 0, 1'b0);
    run_perm({12{32'h0123_4567}}, {12{32'h89AB_CDEF}}, 7, 5, 1'b0);
    run_perm({12{32'hDEAD_BEEF}}, {12{32'h0F0F_1234}}, 0, 0, 1'b1);

    // Mid-run reset while round 6 is in flight (cycle 17 is its WAIT cycle).
    @(negedge clk);
    start = 1'b1; in0 = {12{32'hCAFE_F00D}}; in1 = {12{32'h1357_9BDF}}; rnd_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    check_eq("midrun_busy_before", W'(busy), W'(1));
    rst = 1'b0;
    #1;
    check_eq("midrun_out0", out0, '0);
    check_eq("midrun_out1", out1, '0);
    check_eq("midrun_core_j", W'(cj), '0);
    check_eq("midrun_rdi", crdi, '0);
    check_eq("midrun_busy", W'(busy), '0);
    check_eq("midrun_done", W'(done), '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrun_release_busy", W'(busy), '0);
    check_eq("midrun_release_done", W'(done), '0);
`ifdef XOODOO_PERM_CNT_EN
    exp_perm  = 0;
    exp_stall = 0;
    check_cnts();
`endif
    run_perm({12{32'h7777_0001}}, {12{32'h0000_8888}}, 0, 0, 1'b0);

    // 6-round instance: first token 0x040, done in cycle 19.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      start     = (i == 0);
      rnd_valid = 1'b1;
      rnd       = rnd_of(i);
      #1;
      if (i == 1) check_eq("nr6_first_token", W'(cj6), W'(13'h040));
      if (i > 0) check_eq("nr6_done", W'(done6), W'(i == 19));
    end
    start = 1'b0;
    check_eq("nr6_final_token", W'(cj6), W'(13'h1000));
`ifdef XOODOO_PERM_CNT_EN
    check_eq("nr6_perm_cnt_nonzero", W'(perm_cnt6 != 0), W'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
